// File: rtl/operand_stack_if.sv
// Operand stack command/status bundle: the controller drives cmd/unary/din,
// and the stack returns its top two entries, occupancy and the sticky error flag.
interface operand_stack_if #(
    parameter int unsigned CW = 5
);
    logic [1:0]    cmd;
    logic          unary;
    logic [7:0]    din;
    logic [7:0]    tos;
    logic [7:0]    nos;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err;

    modport master (
        output cmd, unary, din,
        input  tos, nos, count, empty, full, err
    );

    modport slave (
        input  cmd, unary, din,
        output tos, nos, count, empty, full, err
    );
endinterface

// File: rtl/operand_stack.sv
// Register-based 8-bit operand stack feeding an external ALU: single-cycle
// PUSH/POP/ALU writeback with a sticky error flag for illegal operations.
module operand_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 5
) (
    input logic            clk,
    input logic            rst,
    operand_stack_if.slave bus
);
    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_PUSH  = 2'd1,
        CMD_POP   = 2'd2,
        CMD_ALUWB = 2'd3
    } cmd_e;

    cmd_e          cmd;
    logic [7:0]    entry [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] wr_idx;
    logic          wr_en;
    logic          err;
    logic          err_set;
    logic          has_one;
    logic          has_two;
    logic          is_full;
    logic [7:0]    tos;
    logic [7:0]    nos;

    assign cmd     = cmd_e'(bus.cmd);
    assign has_one = (count != '0);
    assign has_two = (count >= CW'(2));
    assign is_full = (count == CW'(DEPTH));

    // Illegal commands only raise err_set; count and entries keep their values.
    always_comb begin
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = '0;
        err_set   = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                if (!is_full) begin
                    wr_en     = 1'b1;
                    wr_idx    = count;
                    count_nxt = count + 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_POP: begin
                if (has_one) begin
                    count_nxt = count - 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_ALUWB: begin
                if (bus.unary) begin
                    if (has_one) begin
                        wr_en  = 1'b1;
                        wr_idx = count - 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else begin
                    if (has_two) begin
                        wr_en     = 1'b1;
                        wr_idx    = count - CW'(2);
                        count_nxt = count - 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == CW'(i))) begin
                    entry[i] <= bus.din;
                end
            end
        end
    end

    // Decode by comparison rather than indexing so unoccupied slots read as zero.
    always_comb begin
        tos = '0;
        nos = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                tos = entry[i];
            end
            if (count == CW'(i + 2)) begin
                nos = entry[i];
            end
        end
    end

    assign bus.tos   = tos;
    assign bus.nos   = nos;
    assign bus.count = count;
    assign bus.empty = !has_one;
    assign bus.full  = is_full;
    assign bus.err   = err;
endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: the driver queues hand-computed results
// per command and a monitor compares them one clock edge later.
module tb_operand_stack;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 5;

    typedef struct {
        logic [7:0]    tos;
        logic [7:0]    nos;
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          err;
        string         name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb [$];
    int   total;
    int   bad;

    operand_stack_if #(.CW(CW)) sif ();

    operand_stack #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [1:0] c, input logic u,
                        input logic [7:0] d, input logic [7:0] et,
                        input logic [7:0] en, input logic [CW-1:0] ec,
                        input logic ee, input logic ef, input logic er,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst       = r;
        sif.cmd   = c;
        sif.unary = u;
        sif.din   = d;
        e.tos   = et;
        e.nos   = en;
        e.count = ec;
        e.empty = ee;
        e.full  = ef;
        e.err   = er;
        e.name  = nm;
        sb.push_back(e);
    endtask

    // Monitor: one result per edge, sampled 1 time unit after the rising edge.
    initial begin
        exp_t e;
        logic [CW+18:0] act;
        logic [CW+18:0] req;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {sif.tos, sif.nos, sif.count, sif.empty, sif.full, sif.err};
                req = {e.tos, e.nos, e.count, e.empty, e.full, e.err};
                total++;
                if (act !== req) begin
                    bad++;
                    $display("FAIL %s: got tos=%h nos=%h count=%0d empty=%b full=%b err=%b, want tos=%h nos=%h count=%0d empty=%b full=%b err=%b",
                             e.name, sif.tos, sif.nos, sif.count, sif.empty, sif.full, sif.err,
                             e.tos, e.nos, e.count, e.empty, e.full, e.err);
                end
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        sif.cmd   = 2'd0;
        sif.unary = 1'b0;
        sif.din   = 8'h00;

        //    rst   cmd  un  din    tos    nos    cnt  emp  ful  err
        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset");
        step(1'b0, 2'd1, 0, 8'h05, 8'h05, 8'h00, 5'd1, 0, 0, 0, "push05");
        step(1'b0, 2'd1, 0, 8'h03, 8'h03, 8'h05, 5'd2, 0, 0, 0, "push03");
        step(1'b0, 2'd3, 0, 8'h08, 8'h08, 8'h00, 5'd1, 0, 0, 0, "aluwb_bin");
        step(1'b0, 2'd3, 1, 8'hF7, 8'hF7, 8'h00, 5'd1, 0, 0, 0, "aluwb_un");
        step(1'b0, 2'd0, 1, 8'hFF, 8'hF7, 8'h00, 5'd1, 0, 0, 0, "nop");
        step(1'b0, 2'd1, 1, 8'h3C, 8'h3C, 8'hF7, 5'd2, 0, 0, 0, "push_unary_ign");
        step(1'b0, 2'd2, 1, 8'h00, 8'hF7, 8'h00, 5'd1, 0, 0, 0, "pop_unary_ign");
        step(1'b0, 2'd2, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "pop_to_empty");

        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset2");
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 2'd1, 0, 8'(i), 8'(i), 8'(i - 1), 5'(i), 0, (i == 8), 0, "fill");
        end
        step(1'b0, 2'd1, 0, 8'hAA, 8'h08, 8'h07, 5'd8, 0, 1, 1, "push_full");
        step(1'b0, 2'd3, 0, 8'h0F, 8'h0F, 8'h06, 5'd7, 0, 0, 1, "aluwb_from_full");
        step(1'b0, 2'd2, 0, 8'h00, 8'h06, 8'h05, 5'd6, 0, 0, 1, "pop_err_sticky");

        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset3");
        step(1'b0, 2'd2, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 1, "pop_empty");
        step(1'b0, 2'd1, 0, 8'h11, 8'h11, 8'h00, 5'd1, 0, 0, 1, "push_after_err");

        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset4");
        step(1'b0, 2'd1, 0, 8'h22, 8'h22, 8'h00, 5'd1, 0, 0, 0, "push22");
        step(1'b0, 2'd3, 0, 8'h99, 8'h22, 8'h00, 5'd1, 0, 0, 1, "aluwb_bin_short");

        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset5");
        step(1'b0, 2'd3, 1, 8'h55, 8'h00, 8'h00, 5'd0, 1, 0, 1, "aluwb_un_empty");

        step(1'b1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 1, 0, 0, "reset6");
        step(1'b0, 2'd1, 0, 8'h40, 8'h40, 8'h00, 5'd1, 0, 0, 0, "push40");
        step(1'b0, 2'd1, 0, 8'h41, 8'h41, 8'h40, 5'd2, 0, 0, 0, "push41");
        step(1'b0, 2'd1, 0, 8'h42, 8'h42, 8'h41, 5'd3, 0, 0, 0, "push42");
        step(1'b1, 2'd1, 0, 8'h77, 8'h00, 8'h00, 5'd0, 1, 0, 0, "rst_over_push");
        step(1'b0, 2'd1, 0, 8'h50, 8'h50, 8'h00, 5'd1, 0, 0, 0, "push_after_rst");
        step(1'b0, 2'd3, 0, 8'h61, 8'h50, 8'h00, 5'd1, 0, 0, 1, "aluwb_bin_one");

        @(negedge clk);
        sif.cmd = 2'd0;
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter DEPTH, default 8: number of 8-bit entries; legal range 2..16.
REQ-002 Parameter CW, default 5: width of count output; SHALL hold the value DEPTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd  input  2  operation: 0 NOP, 1 PUSH, 2 POP, 3 ALUWB (ALU writeback).
REQ-006 unary  input  1  qualifies ALUWB: 1 = unary op (NOT), 0 = binary op (ADD/SUB/AND).
REQ-007 din  input  8  data for PUSH; ALU result for ALUWB.
REQ-008 tos  output  8  top-of-stack entry; drives ALU operand B.
REQ-009 nos  output  8  next-of-stack entry; drives ALU operand A.
REQ-010 count  output  CW  number of valid entries, 0..DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == DEPTH.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 Storage SHALL be DEPTH x 8 registers with stack pointer sp = count; entry index sp-1 is top.
REQ-015 tos SHALL combinationally equal entry[count-1] when count >= 1, else 8'd0.
REQ-016 nos SHALL combinationally equal entry[count-2] when count >= 2, else 8'd0.
REQ-017 empty, full SHALL be combinational decodes of count.
REQ-018 NOP: no state change.
REQ-019 PUSH, count < DEPTH: entry[count] <= din, count <= count+1.
REQ-020 PUSH, count == DEPTH: stack unchanged, err <= 1.
REQ-021 POP, count >= 1: count <= count-1; popped entry value not cleared.
REQ-022 POP, count == 0: stack unchanged, err <= 1.
REQ-023 ALUWB binary, count >= 2: entry[count-2] <= din, count <= count-1 (pop two, push result) in one cycle.
REQ-024 ALUWB unary, count >= 1: entry[count-1] <= din, count unchanged (replace top).
REQ-025 ALUWB binary with count < 2, or unary with count == 0: stack unchanged, err <= 1.
REQ-026 Every legal command SHALL complete in one clock; updated tos/nos/count visible the cycle after the edge.
REQ-027 err, once set, SHALL remain 1 until rst; illegal commands never modify entries or count.
REQ-028 unary SHALL be ignored for cmd != 3.
REQ-029 ALUWB SHALL use only din (no internal arithmetic); zero detection remains in the ALU.

Reset
REQ-030 rst high at a rising edge SHALL set count = 0, err = 0, and all entries to 8'd0, overriding any cmd in that cycle.
REQ-031 After reset: tos = 0, nos = 0, empty = 1, full = 0, err = 0.
REQ-032 rst asserted mid-sequence SHALL discard all stack contents with no partial update.

Verification
REQ-033 Reset, PUSH 8'h05, PUSH 8'h03 -> tos = 03, nos = 05, count = 2, err = 0.
REQ-034 From REQ-033 state, ALUWB binary din = 8'h08 -> tos = 08, nos = 00, count = 1; then ALUWB unary din = 8'hF7 -> tos = F7, count = 1.
REQ-035 DEPTH = 8: push 8'h01..8'h08 -> full = 1, tos = 08; ninth PUSH 8'hAA -> tos = 08, count = 8, err = 1.
REQ-036 Reset, POP -> err = 1, count = 0, empty = 1; subsequent legal PUSH 8'h11 -> tos = 11, err still 1.
REQ-037 count = 1 (tos = 8'h22), ALUWB binary din = 8'h99 -> tos = 22, count = 1, err = 1.
REQ-038 count = 3, cmd = PUSH with rst = 1 on the same edge -> count = 0, tos = 0, err = 0.
